// File: rtl/mu0_mmio_responder.sv
// -----------------------------------------------------------------------------
// mu0_mmio_responder
//
// Target-side MMIO responder for the MU0 delay-0 memory bus. Decodes a 16-word
// window at BASE, answers reads combinationally and commits writes / read side
// effects on the rising clock edge.
//
// Register map (offset = address[3:0]):
//   0 TXDATA  W: push to TX FIFO (drop + sticky tx_ovf when full, no pop)   R: 0
//   1 RXDATA  R: RX head (0 if empty), pops; read while empty sets rx_unf   W: -
//   2 STATUS  R: {rx_occ[7:0], 2'b0, rx_unf, tx_ovf, rx_empty, rx_full,
//                 tx_empty, tx_full}                     W: W1C bits 4 and 5
//   3 CYCLES  R: free-running counter   W: load (reads writedata+1 next cycle)
//   4-15      R: 0, W: ignored
//
// Build option: MU0_MMIO_CYCLE_COUNTER_EN - when defined, the CYCLES counter is
// built; otherwise CYCLES reads 0 and writes to it are ignored.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   address[11:0]     bus word address
//   write, read       bus strobes
//   writedata[15:0]   bus write data
//   readdata[15:0]    combinational read data (0 outside the window)
//   sel               address is inside the window
//   tx_valid/ready/data  TX output stream (data = TX FIFO head)
//   rx_valid/ready/data  RX input stream (ready = RX FIFO not full)
// -----------------------------------------------------------------------------
module mu0_mmio_responder #(
    parameter logic [11:0] BASE       = 12'hFF0,
    parameter int          LOG2_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] address,
    input  logic        write,
    input  logic        read,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        sel,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] tx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [15:0] rx_data
);

    localparam int                DEPTH_I = 1 << LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] DEPTH = DEPTH_I[LOG2_DEPTH:0];

    typedef logic [LOG2_DEPTH-1:0] ptr_t;
    typedef logic [LOG2_DEPTH:0]   cnt_t;

    // FIFO storage is not reset: occupancy and pointers define what is valid.
    logic [15:0] tx_mem_q [DEPTH_I];
    logic [15:0] rx_mem_q [DEPTH_I];

    ptr_t tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    ptr_t rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    cnt_t tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;

    logic [3:0]  off;
    logic        cpu_wr, cpu_rd;
    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic        tx_push_req, tx_push, tx_pop;
    logic        rx_pop_req, rx_pop, rx_push;
    logic [15:0] status;
    logic [15:0] cyc_rd;

    assign off = address[3:0];
    assign sel = (address[11:4] == BASE[11:4]);

    // A simultaneous write wins: the read side effect is suppressed.
    assign cpu_wr = sel & write;
    assign cpu_rd = sel & read & ~write;

    assign tx_full  = (tx_cnt_q == DEPTH);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == DEPTH);
    assign rx_empty = (rx_cnt_q == '0);

    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_mem_q[tx_rptr_q];
    assign rx_ready = ~rx_full;

    assign tx_pop      = tx_valid & tx_ready;
    assign tx_push_req = cpu_wr & (off == 4'd0);
    // A stream pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign tx_push     = tx_push_req & (~tx_full | tx_pop);

    assign rx_push    = rx_valid & rx_ready;
    assign rx_pop_req = cpu_rd & (off == 4'd1);
    // Pop decision sees only the registered state; a same-cycle push into an
    // empty FIFO is not readable yet.
    assign rx_pop     = rx_pop_req & ~rx_empty;

    assign status = {8'(rx_cnt_q), 2'b00, rx_unf_q, tx_ovf_q,
                     rx_empty, rx_full, tx_empty, tx_full};

    always_comb begin
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        tx_cnt_d  = tx_cnt_q;
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        rx_cnt_d  = rx_cnt_q;
        tx_ovf_d  = tx_ovf_q;
        rx_unf_d  = rx_unf_q;

        if (tx_push) tx_wptr_d = tx_wptr_q + ptr_t'(1);
        if (tx_pop)  tx_rptr_d = tx_rptr_q + ptr_t'(1);
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + cnt_t'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - cnt_t'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase

        if (rx_push) rx_wptr_d = rx_wptr_q + ptr_t'(1);
        if (rx_pop)  rx_rptr_d = rx_rptr_q + ptr_t'(1);
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + cnt_t'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - cnt_t'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase

        // Set and clear never coincide: they need different offsets/strobes.
        if (tx_push_req & ~tx_push)  tx_ovf_d = 1'b1;
        if (rx_pop_req & rx_empty)   rx_unf_d = 1'b1;
        if (cpu_wr & (off == 4'd2)) begin
            if (writedata[4]) tx_ovf_d = 1'b0;
            if (writedata[5]) rx_unf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
            tx_ovf_q  <= 1'b0;
            rx_unf_q  <= 1'b0;
        end else begin
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_ovf_q  <= tx_ovf_d;
            rx_unf_q  <= rx_unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wptr_q] <= writedata;
        if (rx_push) rx_mem_q[rx_wptr_q] <= rx_data;
    end

`ifdef MU0_MMIO_CYCLE_COUNTER_EN
    logic [15:0] cyc_q, cyc_d;

    // The load stores writedata+1 so the value read in the cycle after the
    // load already includes that cycle's tick.
    always_comb begin
        cyc_d = cyc_q + 16'd1;
        if (cpu_wr & (off == 4'd3)) cyc_d = writedata + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cyc_q <= '0;
        else      cyc_q <= cyc_d;
    end

    assign cyc_rd = cyc_q;
`else
    assign cyc_rd = '0;
`endif

    always_comb begin
        readdata = '0;
        if (sel) begin
            case (off)
                4'd1:    readdata = rx_empty ? 16'h0000 : rx_mem_q[rx_rptr_q];
                4'd2:    readdata = status;
                4'd3:    readdata = cyc_rd;
                default: readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mu0_mmio_responder.sv
// -----------------------------------------------------------------------------
// tb_mu0_mmio_responder: directed self-checking bench for mu0_mmio_responder.
// -----------------------------------------------------------------------------
module tb_mu0_mmio_responder;

    localparam logic [11:0] A_TX  = 12'hFF0;
    localparam logic [11:0] A_RX  = 12'hFF1;
    localparam logic [11:0] A_ST  = 12'hFF2;
    localparam logic [11:0] A_CYC = 12'hFF3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] address = '0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic        sel;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [15:0] tx_data;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [15:0] rx_data = '0;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_tx [4];

    mu0_mmio_responder dut (
        .clk       (clk),
        .rst       (rst),
        .address   (address),
        .write     (write),
        .read      (read),
        .writedata (writedata),
        .readdata  (readdata),
        .sel       (sel),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance through one rising edge; inputs change and checks happen 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [11:0] a, input logic [15:0] d);
        address = a; writedata = d; write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic cpu_read(input string tag, input logic [11:0] a, input logic [15:0] exp);
        address = a; read = 1'b1;
        #1;
        chk(tag, readdata, exp);
        tick();
        read = 1'b0;
    endtask

    initial begin
        // ---- reset readback
        tick(); tick();
        rst = 1'b1;
        tick();
        address = A_ST;
        #1;
        chk("reset_sel", 16'(sel), 16'd1);
        chk("reset_tx_valid", 16'(tx_valid), 16'd0);
        chk("reset_rx_ready", 16'(rx_ready), 16'd1);
        cpu_read("reset_status", A_ST, 16'h000A);

        // ---- TX order and overflow
        cpu_write(A_TX, 16'h1111);
        chk("tx_valid_after_push", 16'(tx_valid), 16'd1);
        chk("tx_data_after_push", tx_data, 16'h1111);
        cpu_write(A_TX, 16'h2222);
        cpu_write(A_TX, 16'h3333);
        cpu_write(A_TX, 16'h4444);
        cpu_write(A_TX, 16'h5555);
        cpu_read("tx_full_ovf_status", A_ST, 16'h0019);
        chk("tx_data_stable", tx_data, 16'h1111);
        exp_tx[0] = 16'h1111; exp_tx[1] = 16'h2222;
        exp_tx[2] = 16'h3333; exp_tx[3] = 16'h4444;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("tx_order_valid", 16'(tx_valid), 16'd1);
            chk("tx_order_data", tx_data, exp_tx[i]);
            tick();
        end
        chk("tx_drained", 16'(tx_valid), 16'd0);
        tx_ready = 1'b0;
        cpu_read("tx_ovf_held", A_ST, 16'h001A);
        cpu_write(A_ST, 16'h0010);
        cpu_read("tx_ovf_cleared", A_ST, 16'h000A);

        // ---- RX order and underflow
        rx_valid = 1'b1; rx_data = 16'hAAAA;
        tick();
        rx_data = 16'hBBBB;
        tick();
        rx_valid = 1'b0;
        cpu_read("rx_occ2", A_ST, 16'h0202);
        cpu_read("rx_head0", A_RX, 16'hAAAA);
        cpu_read("rx_head1", A_RX, 16'hBBBB);
        cpu_read("rx_empty_read", A_RX, 16'h0000);
        cpu_read("rx_unf_set", A_ST, 16'h002A);
        cpu_write(A_ST, 16'h0030);
        cpu_read("rx_unf_cleared", A_ST, 16'h000A);

        // ---- RX empty: CPU pop and stream push together
        rx_valid = 1'b1; rx_data = 16'hCCCC;
        cpu_read("rx_empty_simul_read", A_RX, 16'h0000);
        rx_valid = 1'b0;
        cpu_read("rx_empty_simul_status", A_ST, 16'h0122);
        cpu_read("rx_empty_simul_word", A_RX, 16'hCCCC);
        cpu_write(A_ST, 16'h0020);

        // ---- read and write together: no pop
        rx_valid = 1'b1; rx_data = 16'hDDDD;
        tick();
        rx_valid = 1'b0;
        address = A_RX; read = 1'b1; write = 1'b1; writedata = 16'h0000;
        #1;
        chk("rw_readdata", readdata, 16'hDDDD);
        tick();
        read = 1'b0; write = 1'b0;
        cpu_read("rw_no_pop", A_ST, 16'h0102);
        cpu_read("rw_word_kept", A_RX, 16'hDDDD);

        // ---- RX full boundary
        rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_data = 16'(16'h0E00 + i);
            tick();
        end
        rx_data = 16'hFFFF;
        #1;
        chk("rx_ready_full", 16'(rx_ready), 16'd0);
        tick();
        rx_valid = 1'b0;
        cpu_read("rx_full_status", A_ST, 16'h0406);
        cpu_read("rx_full_head", A_RX, 16'h0E00);
        #1;
        chk("rx_ready_after_pop", 16'(rx_ready), 16'd1);

        // ---- TX full: CPU push with stream pop in the same cycle
        cpu_write(A_TX, 16'h0101);
        cpu_write(A_TX, 16'h0202);
        cpu_write(A_TX, 16'h0303);
        cpu_write(A_TX, 16'h0404);
        tx_ready = 1'b1;
        cpu_write(A_TX, 16'h9999);
        tx_ready = 1'b0;
        cpu_read("tx_full_simul_status", A_ST, 16'h0301);
        exp_tx[0] = 16'h0202; exp_tx[1] = 16'h0303;
        exp_tx[2] = 16'h0404; exp_tx[3] = 16'h9999;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("tx_simul_order", tx_data, exp_tx[i]);
            tick();
        end
        chk("tx_simul_drained", 16'(tx_valid), 16'd0);
        tx_ready = 1'b0;

        // ---- cycle counter
        cpu_write(A_CYC, 16'hFFFE);
`ifdef MU0_MMIO_CYCLE_COUNTER_EN
        cpu_read("cyc_after_load", A_CYC, 16'hFFFF);
        cpu_read("cyc_wrap", A_CYC, 16'h0000);
`else
        cpu_read("cyc_after_load", A_CYC, 16'h0000);
        cpu_read("cyc_wrap", A_CYC, 16'h0000);
`endif

        // ---- decode
        address = 12'h100;
        #1;
        chk("outside_sel", 16'(sel), 16'd0);
        chk("outside_readdata", readdata, 16'h0000);
        cpu_write(12'h100, 16'h1234);
        cpu_write(12'h102, 16'h0030);
        chk("outside_no_tx", 16'(tx_valid), 16'd0);
        address = 12'hFF7;
        #1;
        chk("off7_sel", 16'(sel), 16'd1);
        chk("off7_readdata", readdata, 16'h0000);
        cpu_write(12'hFF7, 16'h5678);
        cpu_read("decode_status", A_ST, 16'h0302);

        // ---- mid-stream reset
        cpu_write(A_TX, 16'h7777);
        cpu_write(A_TX, 16'h8888);
        address = A_ST;
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_tx_valid", 16'(tx_valid), 16'd0);
        chk("midrst_rx_ready", 16'(rx_ready), 16'd1);
        chk("midrst_status", readdata, 16'h000A);
        tick();
        rst = 1'b1;
        tick();
        cpu_read("post_rst_rx", A_RX, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
